// File: rtl/pipe_cla_adder_if.sv
// -----------------------------------------------------------------------------
// pipe_cla_adder_if
// Purpose : operand/result handshake bundle for pipe_cla_adder.
// Params  : WIDTH - operand/sum width in bits.
// Signals : in_valid/in_ready  - operand beat handshake
//           A, B, Cin, sub     - operands, carry-in, subtract select
//           out_valid/out_ready- result beat handshake
//           S, Cout, OVF       - registered sum, carry-out, signed overflow
//           PG, GG             - word propagate/generate (only when the
//                                CLA_GROUP_PG_EN macro is defined)
// Modports: master drives operands and out_ready; slave is the adder.
// -----------------------------------------------------------------------------
interface pipe_cla_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             OVF;
`ifdef CLA_GROUP_PG_EN
    logic             PG;
    logic             GG;
`endif

    modport master (
        output in_valid, A, B, Cin, sub, out_ready,
`ifdef CLA_GROUP_PG_EN
        input  PG, GG,
`endif
        input  in_ready, out_valid, S, Cout, OVF
    );

    modport slave (
        input  in_valid, A, B, Cin, sub, out_ready,
`ifdef CLA_GROUP_PG_EN
        output PG, GG,
`endif
        output in_ready, out_valid, S, Cout, OVF
    );
endinterface

// File: rtl/pipe_cla_adder.sv
// -----------------------------------------------------------------------------
// pipe_cla_adder
// Purpose : two-stage pipelined carry-lookahead adder/subtractor with a
//           valid/ready handshake on both sides.
//           Stage 1 registers per-bit propagate/generate, per-group P/G and
//           the effective carry-in; stage 2 registers S, Cout and OVF.
//           Latency is two edges from input accept to output transfer.
// Ports   : clk   - clock, rising edge
//           rst_n - asynchronous active-low reset
//           bus   - pipe_cla_adder_if.slave (operands, results, handshakes)
// Params  : WIDTH - operand width, multiple of 4 and >= 4.
// Macro   : CLA_GROUP_PG_EN - when defined, word-level PG/GG outputs are
//           produced and registered in stage 2 alongside S.
// -----------------------------------------------------------------------------
module pipe_cla_adder #(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_cla_adder_if.slave   bus
);
    localparam int GROUP = 4;
    localparam int NGRP  = WIDTH / GROUP;

    generate
        if (WIDTH < GROUP || (WIDTH % GROUP) != 0) begin : g_bad_width
            $error("pipe_cla_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    // Carries into the four bits of one group, fully flattened.
    function automatic logic [3:0] bit_carries(input logic [3:0] g,
                                               input logic [3:0] p,
                                               input logic       c0);
        logic [3:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    function automatic logic group_gen(input logic [3:0] g, input logic [3:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    // Group carries as independent sum-of-products terms per group, so no
    // carry depends on the previously computed one.
    function automatic logic [NGRP:0] group_carries(input logic [NGRP-1:0] gg,
                                                    input logic [NGRP-1:0] gp,
                                                    input logic            c0);
        logic [NGRP:0] c;
        logic          t;
        for (int j = 0; j <= NGRP; j++) begin
            t = c0;
            for (int m = 0; m < j; m++) t = t & gp[m];
            c[j] = t;
            for (int k = 0; k < j; k++) begin
                t = gg[k];
                for (int m = k + 1; m < j; m++) t = t & gp[m];
                c[j] = c[j] | t;
            end
        end
        return c;
    endfunction

`ifdef CLA_GROUP_PG_EN
    function automatic logic word_gen(input logic [NGRP-1:0] gg,
                                      input logic [NGRP-1:0] gp);
        logic acc;
        logic t;
        acc = 1'b0;
        for (int k = 0; k < NGRP; k++) begin
            t = gg[k];
            for (int m = k + 1; m < NGRP; m++) t = t & gp[m];
            acc = acc | t;
        end
        return acc;
    endfunction
`endif

    logic             vld_p1, vld_p2;
    logic             s1_adv;
    logic [WIDTH-1:0] bx_p0, p_p0, g_p0;
    logic [NGRP-1:0]  gp_p0, gg_p0;
    logic             cin_p0;
    logic [WIDTH-1:0] p_p1, g_p1;
    logic [NGRP-1:0]  gp_p1, gg_p1;
    logic             cin_p1;
    logic [NGRP:0]    cg_p1;
    logic [WIDTH-1:0] cb_p1, sum_p1;
    logic             ovf_p1;
    logic [WIDTH-1:0] s_p2;
    logic             cout_p2, ovf_p2;

    assign s1_adv        = !vld_p2 || bus.out_ready;
    assign bus.in_ready  = !vld_p1 || s1_adv;
    assign bus.out_valid = vld_p2;
    assign bus.S         = s_p2;
    assign bus.Cout      = cout_p2;
    assign bus.OVF       = ovf_p2;

    // ---- stage 0 -> 1 : bit and group propagate/generate ----
    always_comb begin
        bx_p0  = bus.sub ? ~bus.B : bus.B;
        p_p0   = bus.A ^ bx_p0;
        g_p0   = bus.A & bx_p0;
        cin_p0 = bus.sub | bus.Cin;
        gp_p0  = '0;
        gg_p0  = '0;
        for (int grp = 0; grp < NGRP; grp++) begin
            gp_p0[grp] = &p_p0[grp*GROUP +: GROUP];
            gg_p0[grp] = group_gen(g_p0[grp*GROUP +: GROUP], p_p0[grp*GROUP +: GROUP]);
        end
    end

    always_ff @(posedge clk) begin
        if (bus.in_valid && bus.in_ready) begin
            p_p1   <= p_p0;
            g_p1   <= g_p0;
            gp_p1  <= gp_p0;
            gg_p1  <= gg_p0;
            cin_p1 <= cin_p0;
        end
    end

    // ---- stage 1 -> 2 : lookahead carries and sum ----
    always_comb begin
        cg_p1 = group_carries(gg_p1, gp_p1, cin_p1);
        cb_p1 = '0;
        for (int grp = 0; grp < NGRP; grp++) begin
            cb_p1[grp*GROUP +: GROUP] = bit_carries(g_p1[grp*GROUP +: GROUP],
                                                    p_p1[grp*GROUP +: GROUP],
                                                    cg_p1[grp]);
        end
        sum_p1 = p_p1 ^ cb_p1;
        // Operand MSBs agree exactly when p is 0 there; g then equals them.
        ovf_p1 = !p_p1[WIDTH-1] && (sum_p1[WIDTH-1] != g_p1[WIDTH-1]);
    end

`ifdef CLA_GROUP_PG_EN
    logic pg_p2, gg_p2;
    assign bus.PG = pg_p2;
    assign bus.GG = gg_p2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_p2    <= '0;
            cout_p2 <= 1'b0;
            ovf_p2  <= 1'b0;
`ifdef CLA_GROUP_PG_EN
            pg_p2   <= 1'b0;
            gg_p2   <= 1'b0;
`endif
        end else if (s1_adv && vld_p1) begin
            s_p2    <= sum_p1;
            cout_p2 <= cg_p1[NGRP];
            ovf_p2  <= ovf_p1;
`ifdef CLA_GROUP_PG_EN
            pg_p2   <= &gp_p1;
            gg_p2   <= word_gen(gg_p1, gp_p1);
`endif
        end
    end

    // ---- valid tracking for both stages ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (bus.in_ready) vld_p1 <= bus.in_valid;
            if (s1_adv)       vld_p2 <= vld_p1;
        end
    end
endmodule

// File: tb/tb_pipe_cla_adder.sv
// -----------------------------------------------------------------------------
// tb_pipe_cla_adder
// Purpose : self-checking bench for pipe_cla_adder (WIDTH=16). Accepted beats
//           push their expected result, computed with plain integer
//           arithmetic, into a queue; an independent monitor pops and
//           compares on every output transfer and checks that held outputs
//           stay stable under backpressure.
// Inputs are driven on the falling edge; out_ready is updated 0.5 ns later,
// the driver samples in_ready at +1 ns and the monitor samples at +2 ns.
// Define CLA_GROUP_PG_EN to also check PG/GG.
// -----------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_pipe_cla_adder;
    localparam int W    = 16;
    localparam int MAXU = (1 << W) - 1;
    localparam int MAXS = (1 << (W - 1)) - 1;
    localparam int MINS = -(1 << (W - 1));

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_cla_adder_if #(.WIDTH(W)) bus ();
    pipe_cla_adder #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
`ifdef CLA_GROUP_PG_EN
        logic         pg;
        logic         gg;
`endif
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   rand_ready  = 1'b0;
    bit   ready_force = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: unsigned sum/difference for S and Cout, signed result range for OVF.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t         e;
        int           ua, ub, sa, sbv, r;
        logic [W-1:0] bx;
        ua  = int'(a);
        ub  = int'(b);
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        if (sub) begin
            e.s    = W'(ua - ub);
            e.cout = (ua >= ub);
            r      = sa - sbv;
        end else begin
            e.s    = W'(ua + ub + int'(cin));
            e.cout = ((ua + ub + int'(cin)) > MAXU);
            r      = sa + sbv + int'(cin);
        end
        e.ovf = (r > MAXS) || (r < MINS);
        bx = sub ? ~b : b;
`ifdef CLA_GROUP_PG_EN
        e.pg = ((a ^ bx) == {W{1'b1}});
        e.gg = ((ua + int'(bx)) > MAXU);
`else
        if (bx == a) e.ovf = e.ovf;
`endif
        return e;
    endfunction

    // out_ready driver: the only process writing out_ready.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            #0.5;
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    // Monitor / scoreboard consumer.
    initial begin
        logic [W-1:0] held_s;
        logic         held_c, held_o;
        bit           prev_stall;
        exp_t         e;
        prev_stall = 1'b0;
        held_s = '0;
        held_c = 1'b0;
        held_o = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", bus.out_valid, 1);
                    check("hold_S", bus.S, held_s);
                    check("hold_Cout", bus.Cout, held_c);
                    check("hold_OVF", bus.OVF, held_o);
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                held_s = bus.S;
                held_c = bus.Cout;
                held_o = bus.OVF;
                if (bus.out_valid && bus.out_ready) begin
                    check("beat_expected", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("S", bus.S, e.s);
                        check("Cout", bus.Cout, e.cout);
                        check("OVF", bus.OVF, e.ovf);
`ifdef CLA_GROUP_PG_EN
                        check("PG", bus.PG, e.pg);
                        check("GG", bus.GG, e.gg);
`endif
                    end
                end
            end
        end
    end

    // Call at a falling edge; returns at the falling edge after the accept.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
        int waited;
        bit done;
        waited = 0;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.A = a;
        bus.B = b;
        bus.Cin = cin;
        bus.sub = sub;
        while (!done) begin
            #1;
            if (bus.in_ready) begin
                sb.push_back(model(a, b, cin, sub));
                done = 1'b1;
                @(posedge clk);
                @(negedge clk);
            end else begin
                waited++;
                if (waited > 100) begin
                    check("accept_timeout_in_ready", bus.in_ready, 1);
                    done = 1'b1;
                end
                @(negedge clk);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    // Single beat into an empty pipe with out_ready=1; checks latency and constants.
    // Returns 1 ns after the falling edge at which the result is presented.
    task automatic latency_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, input logic sub,
                                input logic [W-1:0] es, input logic ec, input logic eo);
        send(a, b, cin, sub);
        #1;
        check("lat_early_valid", bus.out_valid, 0);
        @(negedge clk);
        #1;
        check("lat_out_valid", bus.out_valid, 1);
        check("dir_S", bus.S, es);
        check("dir_Cout", bus.Cout, ec);
        check("dir_OVF", bus.OVF, eo);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.Cin = 1'b0;
        bus.sub = 1'b0;
        rst_n = 1'b0;

        // Reset held while inputs toggle.
        repeat (4) begin
            @(negedge clk);
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.A = W'($urandom);
            bus.B = W'($urandom);
            bus.Cin = 1'($urandom_range(0, 1));
            bus.sub = 1'($urandom_range(0, 1));
            #1;
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_S", bus.S, 0);
            check("rst_Cout", bus.Cout, 0);
            check("rst_OVF", bus.OVF, 0);
            check("rst_in_ready", bus.in_ready, 1);
`ifdef CLA_GROUP_PG_EN
            check("rst_PG", bus.PG, 0);
            check("rst_GG", bus.GG, 0);
`endif
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors.
        latency_beat(16'h0001, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0);
        @(negedge clk);
        latency_beat(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        latency_beat(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        @(negedge clk);
        latency_beat(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        @(negedge clk);
        latency_beat(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
        @(negedge clk);
        latency_beat(16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
`ifdef CLA_GROUP_PG_EN
        check("dir_PG_all_prop", bus.PG, 1);
        check("dir_GG_all_prop", bus.GG, 0);
`endif
        @(negedge clk);
        latency_beat(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
`ifdef CLA_GROUP_PG_EN
        check("dir_GG_msb_gen", bus.GG, 1);
        check("dir_PG_msb_gen", bus.PG, 0);
`endif
        @(negedge clk);

        // Backpressure: two beats held, third stalls, then drain in order.
        ready_force = 1'b0;
        send(16'h1111, 16'h0001, 1'b0, 1'b0);
        send(16'h2222, 16'h0002, 1'b1, 1'b0);
        bus.in_valid = 1'b1;
        bus.A = 16'h3333;
        bus.B = 16'h0003;
        bus.Cin = 1'b0;
        bus.sub = 1'b1;
        repeat (3) begin
            #1;
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_out_valid", bus.out_valid, 1);
            @(negedge clk);
        end
        ready_force = 1'b1;
        send(16'h3333, 16'h0003, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("bp_drained", sb.size(), 0);

        // Reset in the middle of a stream.
        ready_force = 1'b0;
        send(16'h1234, 16'h4321, 1'b0, 1'b0);
        send(16'hABCD, 16'h0101, 1'b0, 1'b1);
        #3;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_out_valid_async", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_S", bus.S, 0);
        @(posedge clk);
        #1;
        check("midrst_out_valid_edge", bus.out_valid, 0);
        @(negedge clk);
        @(negedge clk);
        ready_force = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        latency_beat(16'h0001, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0);
        @(negedge clk);

        // Randomized stream with random backpressure and input gaps.
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rand_ready = 1'b0;
        ready_force = 1'b1;
        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
        check("final_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_cla_adder.md
PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/sum width in bits; SHALL be a multiple of 4 and >= 4, else elaboration error.
REQ-002 Parameter GROUP, fixed 4, lookahead group width in bits; NGRP = WIDTH/4 groups.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B.
REQ-009 Cin  input  1  carry-in, used when sub=0.
REQ-010 sub  input  1  0: A+B+Cin; 1: A-B (A+~B+1, Cin ignored).
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 S  output  WIDTH  registered sum.
REQ-014 Cout  output  1  carry out of MSB (sub=1: 1 = no borrow).
REQ-015 OVF  output  1  signed two's-complement overflow.
REQ-016 PG, GG  output  1 each  word-level propagate/generate; present only with CLA_GROUP_PG_EN.

Function
REQ-017 Beat transfers in when in_valid&&in_ready; out when out_valid&&out_ready.
REQ-018 Two register stages: S1 holds per-group P/G, per-bit p=a^b', effective cin; S2 holds S/Cout/OVF; latency exactly 2 cycles from accept to out_valid with out_ready high.
REQ-019 Carries SHALL use lookahead: c[g+1] = G[g] | P[g]&c[g] within groups and across groups; no bit-serial ripple chain.
REQ-020 Stage advance: s1_adv = !s2_valid || out_ready; in_ready = !s1_valid || s1_adv (combinational from out_ready, no comb path from in_valid).
REQ-021 Throughput one beat per cycle under continuous out_ready=1.
REQ-022 Backpressure: with out_ready=0, at most 2 beats held; S/Cout/OVF stable while out_valid&&!out_ready; no beat dropped, duplicated or reordered.
REQ-023 Simultaneous accept and drain in one cycle with pipeline full SHALL proceed without bubble.
REQ-024 OVF = (a_msb==b'_msb) && (S_msb!=a_msb), b' = sub ? ~B : B.
REQ-025 Wrap-around: sum is modulo 2^WIDTH; carry beyond MSB only on Cout.
REQ-026 When out_valid=0, S/Cout/OVF hold last value (don't-care to consumer, but not X after reset).

Reset
REQ-027 rst_n low SHALL immediately clear s1_valid, s2_valid, out_valid=0, S=0, Cout=0, OVF=0, PG=0, GG=0.
REQ-028 in_ready SHALL be 1 during and after reset.
REQ-029 Reset mid-operation discards all in-flight beats; first beat after release emerges 2 cycles after its accept.

Configuration
REQ-030 Macro CLA_GROUP_PG_EN defined: PG = AND of all group P, GG = word group generate, registered in S2 alongside S.
REQ-031 Macro undefined: PG/GG ports and logic absent; all other behaviour identical.

Verification (WIDTH=16)
REQ-032 Hold rst_n=0, toggle inputs -> out_valid=0, S=0x0000, Cout=0, OVF=0, in_ready=1.
REQ-033 A=0x0001,B=0x0000,Cin=0,sub=0 -> 2 cycles later S=0x0001, Cout=0, OVF=0.
REQ-034 A=0xFFFF,B=0x0001,Cin=0 -> S=0x0000, Cout=1, OVF=0; A=0x7FFF,B=0x0001 -> S=0x8000, OVF=1.
REQ-035 sub=1, A=0x0005,B=0x0007 -> S=0xFFFE, Cout=0; A=0x0007,B=0x0005 -> S=0x0002, Cout=1.
REQ-036 Beats 1,2,3 back-to-back with out_ready=0 -> in_ready=0 after 2 accepted; out_ready=1 -> results in order, none lost; reset asserted mid-stream -> out_valid=0 next edge.
REQ-037 With CLA_GROUP_PG_EN: A=0xFFFF,B=0x0000 -> PG=1, GG=0; A=0x8000,B=0x8000 -> GG=1.
